// File: rtl/mav_pkg.sv
// Shared constants and helpers for the moving-average filter family.
package mav_pkg;

    localparam int MAV_LEVEL = 0;
    localparam int MAV_EDGE  = 1;
    localparam int MAV_TRUNC = 0;
    localparam int MAV_ROUND = 1;

    // Accumulator width: enough headroom for 2^log2_depth full-scale samples.
    function automatic int mav_sum_w(input int dw, input int log2_depth);
        return dw + log2_depth;
    endfunction

endpackage

// File: rtl/mav_strobe.sv
// Sample strobe qualification: registered copy of en plus take generation.
module mav_strobe
    import mav_pkg::*;
#(
    parameter int EDGE_MODE = MAV_EDGE
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    output logic take
);

    logic en_q;

    // en_q tracks en every cycle, including during a flush.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_q <= 1'b0;
        end else begin
            en_q <= en;
        end
    end

    // Edge mode yields a single take per rising edge; level mode takes every cycle.
    always_comb begin
        if (EDGE_MODE == MAV_EDGE) begin
            take = en & ~en_q;
        end else begin
            take = en;
        end
    end

endmodule

// File: rtl/mav_param.sv
// Parametrised moving-average filter over a 2^LOG2_DEPTH sample window.
// Empty slots count as zero, so the average is always sum / N.
module mav_param
    import mav_pkg::*;
#(
    parameter int DW         = 16,
    parameter int LOG2_DEPTH = 2,
    parameter int EDGE_MODE  = MAV_EDGE,
    parameter int ROUND      = MAV_TRUNC
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  clr,
    input  logic [DW-1:0]         d,
    output logic [DW-1:0]         m,
    output logic                  m_valid,
    output logic                  full,
    output logic [LOG2_DEPTH:0]   fill
);

    localparam int N  = 1 << LOG2_DEPTH;
    localparam int SW = mav_sum_w(DW, LOG2_DEPTH);
    localparam logic [LOG2_DEPTH:0] FILL_MAX = (LOG2_DEPTH + 1)'(N);
    // Half an LSB of the result, added before the shift in round-half-up mode.
    localparam logic [SW:0] HALF = (SW + 1)'((ROUND == MAV_ROUND) ? (N >> 1) : 0);

    logic                  take;
    logic [DW-1:0]         buf_mem [N];
    logic [SW-1:0]         sum_q;
    logic [LOG2_DEPTH-1:0] wp_q;
    logic [LOG2_DEPTH:0]   fill_q;
    logic [DW-1:0]         m_q;
    logic                  m_valid_q;
    logic                  full_q;

    logic [SW-1:0]         sum_nxt;
    logic [SW:0]           rnd_w;
    logic [DW-1:0]         m_nxt;
    logic [LOG2_DEPTH:0]   fill_nxt;

    mav_strobe #(
        .EDGE_MODE (EDGE_MODE)
    ) u_strobe (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .take (take)
    );

    // Next running sum, its scaled average, and the saturating fill count.
    // The result cannot exceed 2^DW-1 since sum <= N*(2^DW-1).
    always_comb begin
        sum_nxt  = sum_q + SW'(d) - SW'(buf_mem[wp_q]);
        rnd_w    = {1'b0, sum_nxt} + HALF;
        m_nxt    = DW'(rnd_w >> LOG2_DEPTH);
        fill_nxt = (fill_q == FILL_MAX) ? fill_q : fill_q + (LOG2_DEPTH + 1)'(1);
    end

    // Window, accumulator and registered outputs; flush beats a coincident take.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N; i++) begin
                buf_mem[i] <= '0;
            end
            sum_q     <= '0;
            wp_q      <= '0;
            fill_q    <= '0;
            m_q       <= '0;
            m_valid_q <= 1'b0;
            full_q    <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < N; i++) begin
                buf_mem[i] <= '0;
            end
            sum_q     <= '0;
            wp_q      <= '0;
            fill_q    <= '0;
            m_q       <= '0;
            m_valid_q <= 1'b0;
            full_q    <= 1'b0;
        end else if (take) begin
            buf_mem[wp_q] <= d;
            sum_q         <= sum_nxt;
            wp_q          <= wp_q + LOG2_DEPTH'(1);
            fill_q        <= fill_nxt;
            full_q        <= full_q | (fill_nxt == FILL_MAX);
            m_q           <= m_nxt;
            m_valid_q     <= 1'b1;
        end else begin
            m_valid_q <= 1'b0;
        end
    end

    assign m       = m_q;
    assign m_valid = m_valid_q;
    assign full    = full_q;
    assign fill    = fill_q;

endmodule

// File: tb/tb_mav_param.sv
// Scoreboard bench for mav_param: edge/truncate, edge/round and level/truncate instances.
module tb_mav_param;

    typedef struct packed {
        logic [15:0] m;
        logic [2:0]  fill;
        logic        full;
    } exp_s;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b0, clr = 1'b0;
    logic [15:0] d = '0;
    logic        en_l = 1'b0, clr_l = 1'b0;
    logic [15:0] d_l = '0;

    logic [15:0] m_t, m_r, m_l;
    logic        mv_t, mv_r, mv_l;
    logic        full_t, full_r, full_l;
    logic [2:0]  fill_t, fill_r, fill_l;

    exp_s qt[$];
    exp_s qr[$];
    exp_s ql[$];

    int checks = 0;
    int errors = 0;

    logic [15:0] t2_v [7] = '{16'd2, 16'd2, 16'd3, 16'd3, 16'd5, 16'd2, 16'd1};
    logic [15:0] t2_t [7] = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd3, 16'd2};
    logic [15:0] t2_r [7] = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd3, 16'd3, 16'd3};
    logic [15:0] t3_v [4] = '{16'd3, 16'd2, 16'd2, 16'd2};
    logic [15:0] t3_t [4] = '{16'd0, 16'd1, 16'd1, 16'd2};
    logic [15:0] t3_r [4] = '{16'd1, 16'd1, 16'd2, 16'd2};
    logic [15:0] t5_t [4] = '{16'd1, 16'd2, 16'd3, 16'd5};
    logic [15:0] t5_r [4] = '{16'd1, 16'd3, 16'd4, 16'd5};
    logic [15:0] t6_t [4] = '{16'd16383, 16'd32767, 16'd49151, 16'd65535};
    logic [15:0] t6_r [4] = '{16'd16384, 16'd32768, 16'd49151, 16'd65535};

    always #5 clk = ~clk;

    mav_param #(.DW(16), .LOG2_DEPTH(2), .EDGE_MODE(1), .ROUND(0)) dut_t (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .d(d),
        .m(m_t), .m_valid(mv_t), .full(full_t), .fill(fill_t));

    mav_param #(.DW(16), .LOG2_DEPTH(2), .EDGE_MODE(1), .ROUND(1)) dut_r (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .d(d),
        .m(m_r), .m_valid(mv_r), .full(full_r), .fill(fill_r));

    mav_param #(.DW(16), .LOG2_DEPTH(2), .EDGE_MODE(0), .ROUND(0)) dut_l (
        .clk(clk), .rstn(rstn), .en(en_l), .clr(clr_l), .d(d_l),
        .m(m_l), .m_valid(mv_l), .full(full_l), .fill(fill_l));

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare(input string name, input exp_s e,
                           input logic [15:0] gm, input logic [2:0] gf, input logic gfull);
        check({name, ".m"}, int'(gm), int'(e.m));
        check({name, ".fill"}, int'(gf), int'(e.fill));
        check({name, ".full"}, int'(gfull), int'(e.full));
    endtask

    // Monitors: every m_valid pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (mv_t) begin
            if (qt.size() == 0) check("unexpected_mvalid_t", 1, 0);
            else compare("trunc", qt.pop_front(), m_t, fill_t, full_t);
        end
        if (mv_r) begin
            if (qr.size() == 0) check("unexpected_mvalid_r", 1, 0);
            else compare("round", qr.pop_front(), m_r, fill_r, full_r);
        end
        if (mv_l) begin
            if (ql.size() == 0) check("unexpected_mvalid_l", 1, 0);
            else compare("level", ql.pop_front(), m_l, fill_l, full_l);
        end
    end

    task automatic sample(input logic [15:0] v, input logic [15:0] et, input logic [15:0] er,
                          input logic [2:0] ef, input logic efull);
        @(posedge clk); #1;
        d  = v;
        en = 1'b1;
        qt.push_back('{et, ef, efull});
        qr.push_back('{er, ef, efull});
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic flush();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        check("flush.fill_t", int'(fill_t), 0);
        check("flush.m_r", int'(m_r), 0);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((qt.size() + qr.size() + ql.size()) != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, ".pending"}, qt.size() + qr.size() + ql.size(), 0);
    endtask

    initial begin
        // Reset held with full-scale data and a toggling strobe.
        d = 16'hFFFF;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1 en = ~en;
        end
        @(negedge clk);
        check("rst.m_t", int'(m_t), 0);
        check("rst.fill_t", int'(fill_t), 0);
        check("rst.full_t", int'(full_t), 0);
        check("rst.mv_t", int'(mv_t), 0);
        check("rst.m_r", int'(m_r), 0);
        check("rst.m_l", int'(m_l), 0);
        en = 1'b0;
        #2 rstn = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("post_rst.fill_t", int'(fill_t), 0);

        // Level mode: four consecutive clocks of en take four samples.
        @(posedge clk); #1;
        d_l  = 16'd4;
        en_l = 1'b1;
        ql.push_back('{16'd1, 3'd1, 1'b0});
        ql.push_back('{16'd2, 3'd2, 1'b0});
        ql.push_back('{16'd3, 3'd3, 1'b0});
        ql.push_back('{16'd4, 3'd4, 1'b1});
        repeat (4) @(posedge clk);
        #1 en_l = 1'b0;
        @(negedge clk);
        check("level.fill", int'(fill_l), 4);
        check("level.m", int'(m_l), 4);
        drain("level");

        // Fill and slide.
        for (int i = 0; i < 7; i++) begin
            sample(t2_v[i], t2_t[i], t2_r[i], (i < 3) ? 3'(i + 1) : 3'd4, i >= 3);
        end
        drain("slide");

        // Rounding from an empty window.
        flush();
        for (int i = 0; i < 4; i++) begin
            sample(t3_v[i], t3_t[i], t3_r[i], 3'(i + 1), i == 3);
        end
        drain("round");

        // Long en high produces exactly one take.
        flush();
        @(posedge clk); #1;
        d  = 16'd4;
        en = 1'b1;
        qt.push_back('{16'd1, 3'd1, 1'b0});
        qr.push_back('{16'd1, 3'd1, 1'b0});
        repeat (1000) @(posedge clk);
        #1 en = 1'b0;
        @(negedge clk);
        check("edge.fill_t", int'(fill_t), 1);
        check("edge.fill_r", int'(fill_r), 1);
        drain("edge");

        // Flush coincident with an en rise loses the sample.
        flush();
        for (int i = 0; i < 4; i++) begin
            sample(16'd5, t5_t[i], t5_r[i], 3'(i + 1), i == 3);
        end
        drain("fill5");
        @(posedge clk); #1;
        d   = 16'd5;
        en  = 1'b1;
        clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        check("clr_edge.m_t", int'(m_t), 0);
        check("clr_edge.fill_t", int'(fill_t), 0);
        check("clr_edge.full_t", int'(full_t), 0);
        check("clr_edge.mv_t", int'(mv_t), 0);
        repeat (3) @(posedge clk);
        #1 en = 1'b0;
        sample(16'd8, 16'd2, 16'd2, 3'd1, 1'b0);
        drain("after_clr");

        // Full-scale samples: no wrap in either rounding mode.
        flush();
        for (int i = 0; i < 4; i++) begin
            sample(16'hFFFF, t6_t[i], t6_r[i], 3'(i + 1), i == 3);
        end
        drain("max");

        // Asynchronous reset between edges clears outputs immediately.
        @(negedge clk); #2 rstn = 1'b0;
        #1;
        check("async_rst.m_t", int'(m_t), 0);
        check("async_rst.m_r", int'(m_r), 0);
        check("async_rst.fill_t", int'(fill_t), 0);
        check("async_rst.full_r", int'(full_r), 0);
        check("async_rst.m_l", int'(m_l), 0);
        check("async_rst.full_l", int'(full_l), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mav_param.md
Name: mav_param

Overview:
Parametrised moving-average filter, the successor to MAV.
- Window depth is 2^LOG2_DEPTH; data width is DW.
- Samples are accepted on a qualified strobe: rising edge of en, or level-sensitive en.
- Supports selectable truncate or round-half-up division, synchronous flush, a sample-valid pulse and a window-full flag.
- Sits between the switch/ADC input stage and the display/consumer logic.

Parameters:
DW, 16, sample and result width in bits (>=2)
LOG2_DEPTH, 2, log2 of window depth; depth N = 2^LOG2_DEPTH (1..6)
EDGE_MODE, 1, 1 = one sample per rising edge of en; 0 = one sample every clock while en high
ROUND, 0, 0 = truncate (sum >> LOG2_DEPTH); 1 = round half up ((sum + 2^(LOG2_DEPTH-1)) >> LOG2_DEPTH)

Ports:
clk  in  1  system clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
en  in  1  sample strobe, qualified per EDGE_MODE
clr  in  1  synchronous flush, priority over a sample
d  in  DW  input sample, unsigned
m  out  DW  registered moving average
m_valid  out  1  one-cycle pulse, high the cycle after m updates
full  out  1  high once N samples have been taken since reset/clr
fill  out  LOG2_DEPTH+1  number of valid entries, saturates at N

Behaviour:
- Reset (rstn=0, asynchronous): clear the buffer to 0 and set sum=0, wp=0, fill=0, m=0, m_valid=0, full=0, en_q=0. Deassertion is synchronous to clk in use. Reset mid-operation discards all history.
- en_q is a registered copy of en. take is defined as:
  - EDGE_MODE=1: en & ~en_q
  - EDGE_MODE=0: en
- In EDGE_MODE=1, en held high for any number of cycles produces exactly one take.
- Internal state:
  - buf[0..N-1], each DW bits.
  - wp, LOG2_DEPTH bits; wraps N-1 -> 0 naturally.
  - sum, DW+LOG2_DEPTH bits; never overflows.
- On a clock edge with clr=1:
  - Clear buf, sum, wp, fill, full and m to 0; m_valid=0.
  - en_q still tracks en, so an edge coincident with clr is lost.
- On a clock edge with clr=0 and take=1, all at the same edge (zero latency from take to m):
  - sum <= sum + d - buf[wp]
  - buf[wp] <= d
  - wp <= wp+1
  - fill <= min(fill+1, N)
  - m <= division of the new sum per ROUND
  - m_valid <= 1 for the following cycle
- Otherwise all state holds and m_valid <= 0.
- Before the window is full, empty slots count as 0, so m = sum/N (not sum/fill).
- full is asserted when fill==N and stays high until reset or clr.
- Rounding overflow: the result of ((sum + half) >> L) can reach 2^DW only if sum exceeds N*(2^DW-1), which is impossible. The bench still checks the max value.
- In EDGE_MODE=0, back-to-back takes every cycle are supported; throughput is 1 sample/clock.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package/header mav_pkg:
  - mode constants (MAV_EDGE=1, MAV_LEVEL=0, MAV_TRUNC=0, MAV_ROUND=1)
  - sum-width function (DW+LOG2_DEPTH)
- One sub-module mav_strobe: en_q register plus take generation, parametrised by EDGE_MODE.
- Buffer, sum, pointer and output logic stay in mav_param.

Test Plan:
1. Reset values: rstn=0 with d=16'hFFFF and en toggling -> m=0, fill=0, full=0, m_valid=0. After release, no take until the first en rise.
2. Fill and slide (DW=16, L=2, truncate):
   - samples 2,2,3,3 -> m = 0,1,1,2; full after the 4th sample.
   - then 5 -> m=3 (sum 13).
   - then 2 -> m=3 (sum 13).
   - then 1 -> m=2 (sum 11).
   - m_valid pulses once per sample.
3. Round mode (ROUND=1): samples 3,2,2 -> sums 3,5,7 -> m = 1,1,2. Then 2 -> sum 9 -> m=2.
4. Edge qualification (EDGE_MODE=1): en held high 1000 cycles with d=4 -> fill increments by exactly 1 and one m_valid pulse. With EDGE_MODE=0 and en high for 4 cycles with d=4 -> fill=4, m=4.
5. Flush and simultaneity: after 4 samples of 5 (m=5), clr=1 in the same cycle as an en rise -> m=0, fill=0, full=0, no m_valid. The next en rise with d=8 -> m=2.
6. Saturation and reset mid-run: four samples of 16'hFFFF -> m=16'hFFFF in both ROUND modes, with no wrap. Asserting rstn=0 between clock edges -> all outputs 0 immediately.
